// File: rtl/auth_msg_tx_arbiter_pkg.sv
// Shared authentication defines plus the transmit-engine state and destination types.
`ifndef AUTH_SHARED_DEFINES
`define AUTH_SHARED_DEFINES
`define MSG_LEN                  32
`define HEADER_CERTIFICATE_SLOT0 8'hA0
`define SLOT0_CERT1              24'h5CE101
`define TX_IDLE                  2'd0
`define TX_SEND                  2'd1
`define TX_WAIT_ACK              2'd2
`define TX_RETRY                 2'd3
`define DEST_PD                  1'b0
`define DEST_DEBUG               1'b1
`endif

package auth_msg_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    TX_IDLE     = `TX_IDLE,
    TX_SEND     = `TX_SEND,
    TX_WAIT_ACK = `TX_WAIT_ACK,
    TX_RETRY    = `TX_RETRY
  } tx_state_e;

  localparam logic DEST_PD    = `DEST_PD;
  localparam logic DEST_DEBUG = `DEST_DEBUG;

endpackage

// File: rtl/auth_msg_tx_arbiter_rr_arb.sv
// Two-requester round-robin arbiter; bit 0 = PD, bit 1 = DEBUG.
module auth_tx_rr_arb
  import auth_msg_tx_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic [1:0] grant_o
);

  logic last_grant_q;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_o = 2'b00;
    if (en_i) begin
      if (req_i[0] && (!req_i[1] || (last_grant_q == DEST_DEBUG))) begin
        grant_o[0] = 1'b1;
      end else if (req_i[1]) begin
        grant_o[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= DEST_DEBUG;
    end else if (|grant_o) begin
      last_grant_q <= grant_o[1] ? DEST_DEBUG : DEST_PD;
    end
  end

endmodule

// File: rtl/auth_msg_tx_arbiter.sv
// Transmit engine: arbitrates PD/DEBUG messages, presents them to the driver,
// retransmits on acknowledge timeout and reports done/fail.
module auth_msg_tx_arbiter
  import auth_msg_tx_arbiter_pkg::*;
#(
  parameter int MSG_LEN     = `MSG_LEN,
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_RETRIES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MSG_LEN-1:0] pd_msg,
  input  logic               PD_msg_ready,
  output logic               PD_ready,
  input  logic [MSG_LEN-1:0] debug_msg,
  input  logic               DEBUG_msg_ready,
  output logic               DEBUG_ready,
  output logic [MSG_LEN-1:0] auth_msg_out,
  output logic               auth_msg_ready,
  output logic               auth_msg_dest,
  input  logic               Ack_in_driver,
  output logic               tx_done,
  output logic               tx_fail,
  output logic               busy
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [TW-1:0] TMO_MAX   = TW'(ACK_TIMEOUT);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

  tx_state_e          state_q;
  logic [TW-1:0]      tmo_q;
  logic [TW-1:0]      tmo_d;
  logic [RW-1:0]      retry_q;
  logic [RW-1:0]      retry_d;
  logic [MSG_LEN-1:0] msg_q;
  logic               dest_q;
  logic               ready_q;
  logic               done_q;
  logic               fail_q;
  logic               busy_q;
  logic [1:0]         req;
  logic [1:0]         grant;
  logic               arb_en;

  assign req    = {DEBUG_msg_ready, PD_msg_ready};
  assign arb_en = (state_q == TX_IDLE);

  auth_tx_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req),
    .en_i    (arb_en),
    .grant_o (grant)
  );

  assign PD_ready    = grant[0];
  assign DEBUG_ready = grant[1];

  // tmo_d is the number of ready-high cycles including the current one.
  assign tmo_d   = tmo_q + TW'(1);
  assign retry_d = retry_q + RW'(1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= TX_IDLE;
      tmo_q   <= '0;
      retry_q <= '0;
      msg_q   <= '0;
      dest_q  <= DEST_PD;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      fail_q <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (|grant) begin
            msg_q   <= grant[1] ? debug_msg : pd_msg;
            dest_q  <= grant[1] ? DEST_DEBUG : DEST_PD;
            tmo_q   <= '0;
            retry_q <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= TX_SEND;
          end
        end
        // The acknowledge is deliberately not looked at here: it may still be
        // the trailing level of the previous transfer.
        TX_SEND: begin
          tmo_q   <= tmo_d;
          state_q <= TX_WAIT_ACK;
        end
        TX_WAIT_ACK: begin
          if (Ack_in_driver) begin
            done_q  <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= TX_IDLE;
          end else if (tmo_d == TMO_MAX) begin
            ready_q <= 1'b0;
            if (retry_q < RETRY_MAX) begin
              state_q <= TX_RETRY;
            end else begin
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= TX_IDLE;
            end
          end else begin
            tmo_q <= tmo_d;
          end
        end
        TX_RETRY: begin
          if (retry_q != RETRY_MAX) begin
            retry_q <= retry_d;
          end
          tmo_q   <= '0;
          ready_q <= 1'b1;
          state_q <= TX_SEND;
        end
        default: state_q <= TX_IDLE;
      endcase
    end
  end

  assign auth_msg_out   = msg_q;
  assign auth_msg_ready = ready_q;
  assign auth_msg_dest  = dest_q;
  assign tx_done        = done_q;
  assign tx_fail        = fail_q;
  assign busy           = busy_q;

endmodule

// File: doc/auth_msg_tx_arbiter.md
# auth_msg_tx_arbiter

Transmit-side engine of the authentication controller toward the PD/DEBUG driver. Accepts outbound authentication messages from the PD and DEBUG request sources and arbitrates between them round-robin. Presents the granted message on `auth_msg_out` with `auth_msg_ready` and holds it until the driver answers with `Ack_in_driver`. Retransmits on acknowledge timeout and reports completion or failure.

## Interface
Parameters:
- `MSG_LEN`, default `` `MSG_LEN `` from the shared defines: message width in bits (header plus payload).
- `ACK_TIMEOUT`, default 16: cycles `auth_msg_ready` stays high per attempt before the attempt is abandoned; must be ≥2.
- `MAX_RETRIES`, default 3: extra attempts after the first; 0 means a single attempt.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-low.
- `pd_msg` in MSG_LEN: message from the PD source.
- `PD_msg_ready` in 1: `pd_msg` is valid.
- `PD_ready` out 1: PD message accepted this cycle.
- `debug_msg` in MSG_LEN: message from the DEBUG source.
- `DEBUG_msg_ready` in 1: `debug_msg` is valid.
- `DEBUG_ready` out 1: DEBUG message accepted this cycle.
- `auth_msg_out` out MSG_LEN: message presented to the driver.
- `auth_msg_ready` out 1: `auth_msg_out` is valid and awaiting an acknowledge.
- `auth_msg_dest` out 1: origin of the current message; 0 = PD, 1 = DEBUG.
- `Ack_in_driver` in 1: driver acknowledge (level).
- `tx_done` out 1: one-cycle pulse on acknowledged delivery.
- `tx_fail` out 1: one-cycle pulse when all retries are exhausted.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, SEND, WAIT_ACK, RETRY.
- IDLE:
  - Grant one valid source.
  - `PD_ready`/`DEBUG_ready` = (state==IDLE) && grant; combinational, at most one high.
  - On the capture edge, latch the message and `auth_msg_dest`, clear the timeout and retry counters, then go to SEND.
- Arbitration: round-robin via a `last_grant` register. With both sources valid, grant the one not granted last. Reset value of `last_grant` = DEBUG, so PD wins the first tie.
- SEND: first cycle of `auth_msg_ready`=1. `Ack_in_driver` is ignored here, which rejects the stale acknowledge trailing the previous transfer. Always go to WAIT_ACK.
- WAIT_ACK: `auth_msg_ready`=1.
  - `Ack_in_driver` sampled 1: pulse `tx_done`, go to IDLE.
  - Otherwise, when the attempt counter reaches ACK_TIMEOUT: go to RETRY if retries < MAX_RETRIES, else pulse `tx_fail` and go to IDLE.
- RETRY: one cycle with `auth_msg_ready`=0; increment the retry count; go to SEND. The message is unchanged.
- `Ack_in_driver` in IDLE or RETRY is ignored.
- `auth_msg_out` holds the last captured value while idle.
- Ack and timeout on the same edge: ack wins (`tx_done`, no retry).
- Reset mid-transfer: the message is dropped and all outputs return to reset values. No `tx_fail` is issued.

## Timing
- Reset values: `auth_msg_out`=0, `auth_msg_ready`=0, `auth_msg_dest`=0, `tx_done`=0, `tx_fail`=0, `busy`=0, `PD_ready`=0, `DEBUG_ready`=0.
- Message captured at edge N. `auth_msg_ready` is high from cycle N+1 (SEND).
- A driver that registers the acknowledge from `auth_msg_ready` raises `Ack_in_driver` in N+2. It is sampled at the end of N+2, with `tx_done` high in N+3 and state IDLE in N+3.
- Minimum spacing between captures is 3 cycles. There is 1 dead IDLE cycle with `auth_msg_ready` low between messages.
- Timeout counter: width $clog2(ACK_TIMEOUT+1). It counts cycles with `auth_msg_ready` high (SEND counts as 1). Expiry is detected when the count equals ACK_TIMEOUT.
- Retry counter: width $clog2(MAX_RETRIES+1); saturates, never wraps.
- All outputs except `PD_ready`/`DEBUG_ready` are registered.

## Structure
- Shared defines file (existing `` `MSG_LEN `` and header/certificate constants) gains:
  - state encodings `TX_IDLE`/`TX_SEND`/`TX_WAIT_ACK`/`TX_RETRY`;
  - destination codes `DEST_PD`=0, `DEST_DEBUG`=1.
- One sub-module: `auth_tx_rr_arb`, a 2-requester round-robin arbiter (requests, enable, grant, `last_grant` update on accept).
- The FSM, counters and message register stay in the top.

## Test plan
- PD only, `pd_msg`={`HEADER_CERTIFICATE_SLOT0`,`SLOT0_CERT1`}, driver acks one cycle after seeing ready -> `PD_ready` pulse at N, `auth_msg_out` equals the message, `auth_msg_dest`=0, `tx_done` at N+3.
- PD and DEBUG both valid continuously -> grants alternate PD, DEBUG, PD, DEBUG; each message delivered exactly once; no source starved.
- Driver never acks, ACK_TIMEOUT=4, MAX_RETRIES=2 -> three 4-cycle `auth_msg_ready` windows separated by 1 low cycle; `tx_fail` pulses once; `tx_done` never.
- `Ack_in_driver` held high across back-to-back messages -> the stale ack in the IDLE/SEND cycle is ignored; each message completes only via an ack sampled in WAIT_ACK.
- `reset` driven low during WAIT_ACK -> next cycle all outputs at reset values; after release, PD wins the first tie.
